// File: rtl/imem_refill_responder.sv
// Purpose : memory-side responder for icache refills; serves one cache line as a timed burst
//           of WORDS beats from a preloadable word-addressed instruction RAM.
// Latency : request accepted at edge E0; first beat visible after E(LATENCY+1), one beat per cycle.
// Backpressure: none - the cache must take every beat; the request must stay high until the burst
//           starts (dropping it in WAIT aborts), and must go low before the next request is accepted.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   mem_req_i         refill request (held with a stable mem_addr_i until served)
//   mem_addr_i        byte address of the missing line
//   mem_valid_o       beat valid, one word per cycle
//   mem_inst_o        beat data (holds its last value while mem_valid_o is low)
//   mem_beat_o        word offset within the line of the current beat
//   busy_o            high whenever the FSM is not IDLE
//   init_we_i/init_addr_i/init_data_i  RAM preload write port, usable in any state
//
// Build option: define REFILL_CRITICAL_WORD_FIRST_EN to deliver the requested word first and
// wrap around the line; otherwise beats always go out in linear order 0..WORDS-1.

module imem_refill_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      mem_req_i,
    input  logic [ADDR_WIDTH-1:0]                     mem_addr_i,
    output logic                                      mem_valid_o,
    output logic [WORD_WIDTH-1:0]                     mem_inst_o,
    output logic [$clog2(LINE_WIDTH/WORD_WIDTH)-1:0]  mem_beat_o,
    output logic                                      busy_o,
    input  logic                                      init_we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0]              init_addr_i,
    input  logic [WORD_WIDTH-1:0]                     init_data_i
);

    localparam int WORDS = LINE_WIDTH / WORD_WIDTH;
    localparam int BW    = $clog2(WORDS);
    localparam int IW    = $clog2(MEM_DEPTH);
    localparam int LW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_BURST   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Instruction RAM (not reset). A read in the same cycle as a write to
    // the same word returns the old contents.
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] ram [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (init_we_i) begin
            ram[init_addr_i] <= init_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Address decode: word index wraps modulo MEM_DEPTH.
    // ------------------------------------------------------------------
    logic [IW-1:0] req_word;
    assign req_word = mem_addr_i[2 +: IW];

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   lat_cnt;
    logic [BW-1:0]   beat_cnt;
    logic [IW-BW-1:0] line_idx;
    logic [BW-1:0]   start_off;

    logic            accept;
    logic            burst_step;
    logic [BW-1:0]   rd_off;
    logic [IW-1:0]   rd_addr;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    // Requested word first, then wrap around the line.
    assign rd_off = start_off + beat_cnt;
    logic addr_unused;
    assign addr_unused = ^{mem_addr_i[ADDR_WIDTH-1:2+IW], mem_addr_i[1:0]};
`else
    // Linear order; the start offset is latched but does not steer the burst.
    assign rd_off = beat_cnt;
    logic addr_unused;
    assign addr_unused = ^{mem_addr_i[ADDR_WIDTH-1:2+IW], mem_addr_i[1:0], start_off};
`endif

    assign rd_addr = {line_idx, rd_off};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        burst_step = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_req_i) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A dropped request wins over an expiring counter.
                if (!mem_req_i) begin
                    state_nxt = ST_IDLE;
                end else if (lat_cnt == '0) begin
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                // Request is ignored here: a started burst always completes.
                burst_step = 1'b1;
                if (beat_cnt == BW'(WORDS - 1)) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Wait for the request to fall so a held request cannot retrigger.
                if (!mem_req_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Counters, latched request and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_cnt     <= '0;
            beat_cnt    <= '0;
            line_idx    <= '0;
            start_off   <= '0;
            mem_valid_o <= 1'b0;
            mem_inst_o  <= '0;
            mem_beat_o  <= '0;
            busy_o      <= 1'b0;
        end else begin
            busy_o      <= (state_nxt != ST_IDLE);
            mem_valid_o <= burst_step;

            if (accept) begin
                line_idx  <= req_word[IW-1:BW];
                start_off <= req_word[BW-1:0];
                lat_cnt   <= LW'(LATENCY - 1);
                beat_cnt  <= '0;
            end

            if (state == ST_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (burst_step) begin
                mem_inst_o <= ram[rd_addr];
                mem_beat_o <= rd_off;
                beat_cnt   <= beat_cnt + 1'b1;
            end
        end
    end

endmodule
